exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception and interrupt controller that feeds the CP0 register block. It collects exception flags from the commit stage, and synchronizes and masks the hardware interrupt lines against CP0 state. It picks the highest-priority event and presents it to CP0 as exception/eret in the commit cycle. It then drives a held flush/redirect handshake to the fetch unit: exception vector or EPC.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, target PC for every exception.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- commit_valid  in  1  an instruction commits this cycle
- commit_pc  in  32  PC of the committing instruction
- commit_in_delay_slot  in  1  committing instruction is in a branch delay slot
- commit_exc_flags  in  7  {adel_if, ri, ov, sys, bp, adel_mem, ades_mem}
- commit_eret  in  1  committing instruction is ERET
- mem_addr  in  32  data address for AdEL/AdES
- ext_int  in  6  asynchronous hardware interrupt lines
- status_ie, status_exl  in  1 each  from CP0
- status_im  in  8  from CP0
- cause_ip_sw  in  2  software IP[1:0] from CP0
- cp0_epc, cp0_count, cp0_compare  in  32 each  from CP0
- compare_we  in  1  mtc0 to Compare this cycle
- exc_valid  out  1  exception to CP0
- exc_code  out  5  ExcCode
- exc_pc  out  32  faulting PC
- exc_in_delay_slot  out  1  delay-slot flag
- exc_badvaddr  out  32  BadVAddr value
- eret_out  out  1  eret to CP0
- hw_ip  out  6  IP[7:2] to CP0 Cause
- flush  out  1  kill all younger pipeline stages
- commit_stall  out  1  blocks further commits while a redirect is pending
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect

## Operation
- Interrupt lines:
  - ext_int passes through a 2-flop synchronizer, giving ext_s.
  - ip = {ext_s[5] | timer_ip, ext_s[4:0], cause_ip_sw}.
  - hw_ip = ip[7:2].
- Interrupt pending: int_pend = status_ie & ~status_exl & |(ip & status_im).
- An event is taken only when commit_valid=1 and the FSM is IDLE.
- Priority, highest first, with ExcCode:
  - interrupt 0x00
  - adel_if 0x04, badvaddr = commit_pc
  - ri 0x0A
  - ov 0x0C
  - sys 0x08
  - bp 0x09
  - adel_mem 0x04, badvaddr = mem_addr
  - ades_mem 0x05, badvaddr = mem_addr
- Exception taken:
  - exc_valid=1, exc_pc=commit_pc, exc_in_delay_slot passed through.
  - flush=1.
  - Redirect target is EXC_VECTOR.
  - eret_out is suppressed even if commit_eret=1.
- ERET with no exception: eret_out=1, flush=1, redirect target = cp0_epc sampled in that cycle.
- exc_badvaddr is 0 for codes other than AdEL/AdES.
- FSM:
  - IDLE: on a taken event, latch the target and go to REDIR.
  - REDIR: redirect_valid=1, commit_stall=1, redirect_pc stable. When redirect_ready=1, go to IDLE.
- Timer (see Configuration):
  - timer_ip sets when cp0_count == cp0_compare.
  - compare_we clears it; the clear wins over a same-cycle set.
  - timer_ip is sticky otherwise.

## Timing
- Reset values: all outputs 0, FSM IDLE, synchronizer flops 0, timer_ip 0.
- Reset asserted mid-REDIR drops redirect_valid immediately (async) and returns the FSM to IDLE.
- exc_valid, exc_code, exc_pc, exc_badvaddr, eret_out and flush are combinational in commit cycle T. CP0 captures them at the end of T.
- redirect_valid rises in T+1 and holds until the first cycle with redirect_ready=1, inclusive. It falls in the next cycle.
- Minimum redirect latency is one cycle: ready=1 in T+1 gives IDLE in T+2.
- ext_int to hw_ip/int_pend latency is 2 cycles.
- status_exl=1 from a prior exception masks interrupts. No interrupt is taken while status_exl=1, even with status_ie=1.
- While in REDIR, commit_valid is ignored (commit_stall=1). flush is not re-asserted.

## Configuration
- TIMER_INT_EN:
  - Defined: the count/compare timer logic is built and timer_ip is ORed into IP7.
  - Undefined: timer_ip is constant 0, compare_we/cp0_count/cp0_compare are unused, and IP7 = ext_s[5] only.

## Test plan
- Commit at pc=0x8000_0010 with ov=1, redirect_ready=1 -> in T: exc_valid=1, exc_code=0x0C, flush=1. In T+1: redirect_valid=1, redirect_pc=0xBFC0_0380. In T+2: redirect_valid=0.
- Commit with ri=1 and sys=1, delay slot=1, pc=0x8000_0104 -> exc_code=0x0A, exc_in_delay_slot=1, exc_pc=0x8000_0104.
- status_ie=1, status_exl=0, status_im=0x04, ext_int[0] raised -> no exception for 2 cycles. On the next commit: exc_code=0x00, overriding a same-cycle bp=1. The same scenario with status_exl=1 -> no exception.
- Commit eret with cp0_epc=0x8000_2000, redirect_ready low for 3 cycles -> eret_out=1 for one cycle. redirect_valid holds 0x8000_2000 for 4 cycles, commit_stall=1 throughout, and commits arriving during the hold are ignored.
- With TIMER_INT_EN: count==compare -> hw_ip[5]=1. compare_we in the same cycle as a match -> hw_ip[5] stays 0. Without TIMER_INT_EN -> hw_ip[5] tracks ext_int[5] only.
- Assert reset during REDIR -> redirect_valid=0 and commit_stall=0 immediately. After reset releases, the first faulting commit is handled normally.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception / interrupt controller in front of the CP0 block.
//
// Collects commit-stage exception flags and synchronized, masked hardware
// interrupts. It picks the highest-priority event and reports it to CP0
// combinationally in the commit cycle. It then holds a flush/redirect
// handshake to fetch until fetch accepts it. The target is the exception
// vector or EPC.
//
// Optional feature macro: TIMER_INT_EN
//   defined   -> count/compare timer built, timer_ip ORed into IP7
//   undefined -> timer_ip tied 0, compare_we/cp0_count/cp0_compare unused
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   commit_*                   committing instruction: valid, pc, delay slot,
//                              exception flags
//                              {adel_if,ri,ov,sys,bp,adel_mem,ades_mem}, eret
//   mem_addr                   data address reported for AdEL/AdES
//   ext_int                    asynchronous hardware interrupt lines
//   status_*, cause_ip_sw      CP0 interrupt enable / mask / software IP state
//   cp0_epc                    ERET return target
//   cp0_count, cp0_compare,
//   compare_we                 timer inputs
//   exc_*, eret_out            event report to CP0 (combinational)
//   hw_ip                      IP[7:2] for CP0 Cause
//   flush                      kill younger stages (commit cycle only)
//   commit_stall               held while a redirect is outstanding
//   redirect_valid/pc/ready    redirect handshake with fetch
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_in_delay_slot,
  input  logic [6:0]  commit_exc_flags,
  input  logic        commit_eret,
  input  logic [31:0] mem_addr,
  input  logic [5:0]  ext_int,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_count,
  input  logic [31:0] cp0_compare,
  input  logic        compare_we,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        exc_in_delay_slot,
  output logic [31:0] exc_badvaddr,
  output logic        eret_out,
  output logic [5:0]  hw_ip,
  output logic        flush,
  output logic        commit_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t      state_reg, state_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
  logic [5:0]  ext_meta_reg, ext_s_reg;
  logic        timer_ip;
  logic [7:0]  ip;
  logic        int_pend;
  logic        exc_hit;

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_meta_reg <= '0;
      ext_s_reg    <= '0;
    end else begin
      ext_meta_reg <= ext_int;
      ext_s_reg    <= ext_meta_reg;
    end
  end

`ifdef TIMER_INT_EN
  logic timer_ip_reg;

  // Sticky match flag; a Compare write clears it and beats a same-cycle match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer_ip_reg <= 1'b0;
    else if (compare_we)
      timer_ip_reg <= 1'b0;
    else if (cp0_count == cp0_compare)
      timer_ip_reg <= 1'b1;
  end

  assign timer_ip = timer_ip_reg;
`else
  logic unused_timer;
  assign unused_timer = ^{compare_we, cp0_count, cp0_compare};
  assign timer_ip     = 1'b0;
`endif

  assign ip       = {ext_s_reg[5] | timer_ip, ext_s_reg[4:0], cause_ip_sw};
  assign hw_ip    = ip[7:2];
  assign int_pend = status_ie & ~status_exl & (|(ip & status_im));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    redirect_pc_next  = redirect_pc_reg;
    exc_hit           = 1'b0;
    exc_valid         = 1'b0;
    exc_code          = 5'h00;
    exc_pc            = '0;
    exc_in_delay_slot = 1'b0;
    exc_badvaddr      = '0;
    eret_out          = 1'b0;
    flush             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (commit_valid) begin
          // Priority chain, highest first. Interrupt code 0x00 is the default.
          if (int_pend) begin
            exc_hit  = 1'b1;
          end else if (commit_exc_flags[6]) begin
            exc_hit      = 1'b1;
            exc_code     = 5'h04;
            exc_badvaddr = commit_pc;
          end else if (commit_exc_flags[5]) begin
            exc_hit  = 1'b1;
            exc_code = 5'h0A;
          end else if (commit_exc_flags[4]) begin
            exc_hit  = 1'b1;
            exc_code = 5'h0C;
          end else if (commit_exc_flags[3]) begin
            exc_hit  = 1'b1;
            exc_code = 5'h08;
          end else if (commit_exc_flags[2]) begin
            exc_hit  = 1'b1;
            exc_code = 5'h09;
          end else if (commit_exc_flags[1]) begin
            exc_hit      = 1'b1;
            exc_code     = 5'h04;
            exc_badvaddr = mem_addr;
          end else if (commit_exc_flags[0]) begin
            exc_hit      = 1'b1;
            exc_code     = 5'h05;
            exc_badvaddr = mem_addr;
          end

          if (exc_hit) begin
            // An exception overrides a same-cycle ERET.
            exc_valid         = 1'b1;
            exc_pc            = commit_pc;
            exc_in_delay_slot = commit_in_delay_slot;
            flush             = 1'b1;
            state_next        = REDIR;
            redirect_pc_next  = EXC_VECTOR;
          end else if (commit_eret) begin
            eret_out         = 1'b1;
            flush            = 1'b1;
            state_next       = REDIR;
            redirect_pc_next = cp0_epc;
          end
        end
      end
      REDIR: begin
        if (redirect_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign redirect_valid = (state_reg == REDIR);
  assign commit_stall   = (state_reg == REDIR);
  assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the controller.
module tb_exc_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_in_delay_slot;
  logic [6:0]  commit_exc_flags;
  logic        commit_eret;
  logic [31:0] mem_addr;
  logic [5:0]  ext_int;
  logic        status_ie, status_exl;
  logic [7:0]  status_im;
  logic [1:0]  cause_ip_sw;
  logic [31:0] cp0_epc, cp0_count, cp0_compare;
  logic        compare_we;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic [31:0] exc_badvaddr;
  logic        eret_out;
  logic [5:0]  hw_ip;
  logic        flush, commit_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic        m_busy;
  logic [31:0] m_target;
  logic [5:0]  m_q[$];   // ext_int sampled at each rising edge
  logic        m_timer;

  exc_ctrl dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_in_delay_slot(commit_in_delay_slot),
    .commit_exc_flags(commit_exc_flags), .commit_eret(commit_eret),
    .mem_addr(mem_addr), .ext_int(ext_int),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .cause_ip_sw(cause_ip_sw), .cp0_epc(cp0_epc), .cp0_count(cp0_count),
    .cp0_compare(cp0_compare), .compare_we(compare_we),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_in_delay_slot(exc_in_delay_slot), .exc_badvaddr(exc_badvaddr),
    .eret_out(eret_out), .hw_ip(hw_ip), .flush(flush),
    .commit_stall(commit_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got=%h exp=%h", tag, what, got, exp);
    end
  endtask

  function automatic logic [4:0] code_of(input int i);
    case (i)
      6: return 5'h04;
      5: return 5'h0A;
      4: return 5'h0C;
      3: return 5'h08;
      2: return 5'h09;
      1: return 5'h04;
      default: return 5'h05;
    endcase
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_target = '0;
    m_q.delete();
    m_timer  = 1'b0;
  endtask

  task automatic idle_inputs();
    commit_valid         = 1'b0;
    commit_pc            = '0;
    commit_in_delay_slot = 1'b0;
    commit_exc_flags     = '0;
    commit_eret          = 1'b0;
    mem_addr             = '0;
  endtask

  // Called just after a falling edge with inputs applied. Checks every
  // output against the model, clocks once, advances the model.
  task automatic step(input string tag);
    logic [5:0]  es;
    logic [7:0]  ip;
    logic        tmr, pend, hit, ev_eret;
    logic [4:0]  code;
    logic [31:0] bv;
    #2;
    es = (m_q.size() >= 2) ? m_q[m_q.size()-2] : 6'd0;
`ifdef TIMER_INT_EN
    tmr = m_timer;
`else
    tmr = 1'b0;
`endif
    ip   = {es[5] | tmr, es[4:0], cause_ip_sw};
    pend = status_ie & ~status_exl & (|(ip & status_im));
    hit  = 1'b0;
    code = 5'h00;
    bv   = '0;
    if (commit_valid && !m_busy) begin
      if (pend) hit = 1'b1;
      else begin
        for (int i = 6; i >= 0; i--) begin
          if (!hit && commit_exc_flags[i]) begin
            hit  = 1'b1;
            code = code_of(i);
            if (i == 6) bv = commit_pc;
            else if (i <= 1) bv = mem_addr;
          end
        end
      end
    end
    ev_eret = commit_valid && !m_busy && !hit && commit_eret;
    chk(tag, "exc_valid", exc_valid, hit);
    chk(tag, "exc_code", exc_code, code);
    chk(tag, "exc_pc", exc_pc, hit ? commit_pc : 32'd0);
    chk(tag, "exc_ds", exc_in_delay_slot, hit & commit_in_delay_slot);
    chk(tag, "badvaddr", exc_badvaddr, bv);
    chk(tag, "eret_out", eret_out, ev_eret);
    chk(tag, "flush", flush, hit | ev_eret);
    chk(tag, "hw_ip", hw_ip, ip[7:2]);
    chk(tag, "redirect_valid", redirect_valid, m_busy);
    chk(tag, "commit_stall", commit_stall, m_busy);
    if (m_busy) chk(tag, "redirect_pc", redirect_pc, m_target);
    if (hit || ev_eret)
      $display("txn %s: pc=%h exc=%0b code=%h eret=%0b badvaddr=%h",
               tag, commit_pc, hit, code, ev_eret, bv);
    @(posedge clk);
    if (m_busy) begin
      if (redirect_ready) m_busy = 1'b0;
    end else if (hit || ev_eret) begin
      m_busy   = 1'b1;
      m_target = hit ? VEC : cp0_epc;
    end
    m_q.push_back(ext_int);
    if (m_q.size() > 3) void'(m_q.pop_front());
    if (compare_we) m_timer = 1'b0;
    else if (cp0_count == cp0_compare) m_timer = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    ext_int = '0; status_ie = 0; status_exl = 0; status_im = '0;
    cause_ip_sw = '0; cp0_epc = '0; cp0_count = 32'd0; cp0_compare = 32'd1;
    compare_we = 0; redirect_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset", "redirect_valid", redirect_valid, 1'b0);
    chk("reset", "commit_stall", commit_stall, 1'b0);
    chk("reset", "redirect_pc", redirect_pc, 32'd0);
    chk("reset", "hw_ip", hw_ip, 6'd0);
    chk("reset", "exc_valid", exc_valid, 1'b0);
    reset = 1'b0;

    // Overflow with immediate accept
    commit_valid = 1; commit_pc = 32'h8000_0010; commit_exc_flags = 7'b0010000;
    redirect_ready = 1;
    #1 chk("ov", "code_c", exc_code, 5'h0C);
    chk("ov", "flush_c", flush, 1'b1);
    step("ov");
    idle_inputs();
    #1 chk("ov_t1", "rv_c", redirect_valid, 1'b1);
    chk("ov_t1", "rpc_c", redirect_pc, VEC);
    step("ov_t1");
    #1 chk("ov_t2", "rv_c", redirect_valid, 1'b0);
    step("ov_t2");

    // ri beats sys, delay slot
    commit_valid = 1; commit_pc = 32'h8000_0104; commit_exc_flags = 7'b0101000;
    commit_in_delay_slot = 1;
    #1 chk("ri", "code_c", exc_code, 5'h0A);
    chk("ri", "ds_c", exc_in_delay_slot, 1'b1);
    chk("ri", "pc_c", exc_pc, 32'h8000_0104);
    step("ri");
    idle_inputs();
    step("ri_t1");

    // Interrupt over bp, after synchronizer latency
    status_ie = 1; status_im = 8'h04; ext_int = 6'b000001;
    commit_valid = 1; commit_pc = 32'h8000_0200;
    step("int_w0");
    step("int_w1");
    commit_exc_flags = 7'b0000100;
    #1 chk("int", "code_c", exc_code, 5'h00);
    chk("int", "valid_c", exc_valid, 1'b1);
    step("int");
    idle_inputs();
    step("int_t1");
    status_exl = 1; commit_valid = 1; commit_pc = 32'h8000_0300;
    #1 chk("int_exl", "valid_c", exc_valid, 1'b0);
    step("int_exl");
    idle_inputs();
    status_exl = 0; status_ie = 0; ext_int = '0;
    step("int_clr0");
    step("int_clr1");

    // ERET with a slow fetch
    cp0_epc = 32'h8000_2000; redirect_ready = 0;
    commit_valid = 1; commit_eret = 1; commit_pc = 32'h8000_0400;
    #1 chk("eret", "eret_c", eret_out, 1'b1);
    step("eret");
    commit_eret = 0; commit_exc_flags = 7'b0010000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("eret_hold", "rpc_c", redirect_pc, 32'h8000_2000);
      chk("eret_hold", "ignored_c", exc_valid, 1'b0);
      step("eret_hold");
    end
    redirect_ready = 1;
    #1 chk("eret_acc", "rv_c", redirect_valid, 1'b1);
    step("eret_acc");
    idle_inputs();
    #1 chk("eret_done", "rv_c", redirect_valid, 1'b0);
    step("eret_done");

    // Timer
    cp0_count = 32'd5; cp0_compare = 32'd5;
    step("tmr_match");
`ifdef TIMER_INT_EN
    #1 chk("tmr", "ip7_c", hw_ip[5], 1'b1);
`else
    #1 chk("tmr", "ip7_c", hw_ip[5], 1'b0);
`endif
    compare_we = 1;
    step("tmr_clear");
    step("tmr_we_match");
    #1 chk("tmr_we", "ip7_c", hw_ip[5], 1'b0);
    cp0_count = 32'd0; cp0_compare = 32'd1; ext_int = 6'h20;
    step("ext5_a");
    step("ext5_b");
    #1 chk("ext5", "ip7_c", hw_ip[5], 1'b1);
    ext_int = '0; compare_we = 0;
    step("ext5_c");
    step("ext5_d");

    // Reset in REDIR
    redirect_ready = 0; commit_valid = 1; commit_pc = 32'h8000_0500;
    commit_exc_flags = 7'b0010000;
    step("rst_enter");
    idle_inputs();
    step("rst_hold");
    #1 reset = 1'b1;
    #1 chk("rst_mid", "rv_c", redirect_valid, 1'b0);
    chk("rst_mid", "stall_c", commit_stall, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    redirect_ready = 1; commit_valid = 1; commit_pc = 32'h8000_0600;
    commit_exc_flags = 7'b0000010; mem_addr = 32'h1234_5679;
    #1 chk("rst_after", "code_c", exc_code, 5'h04);
    chk("rst_after", "bv_c", exc_badvaddr, 32'h1234_5679);
    step("rst_after");
    idle_inputs();
    step("rst_after_t1");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      commit_valid         = $urandom_range(0, 1);
      commit_pc            = $urandom;
      commit_in_delay_slot = $urandom_range(0, 1);
      commit_exc_flags     = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      commit_eret          = ($urandom_range(0, 5) == 0);
      mem_addr             = $urandom;
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
      status_ie            = $urandom_range(0, 1);
      status_exl           = ($urandom_range(0, 3) == 0);
      status_im            = 8'($urandom);
      cause_ip_sw          = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
      cp0_epc              = $urandom;
      cp0_count            = $urandom_range(0, 3);
      cp0_compare          = $urandom_range(0, 3);
      compare_we           = ($urandom_range(0, 3) == 0);
      redirect_ready       = $urandom_range(0, 1);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
